// File: rtl/perfcnt_bank.sv
// Bank of NUM_CNT event counters behind an AXI4-Lite slave with global enable,
// clear-all, per-counter preset and tear-free 64-bit reads via a shared shadow.
module perfcnt_bank #(
  parameter int NUM_CNT = 16,
  parameter int CNT_W   = 64,
  parameter int ADDR_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_axilite_awaddr,
  input  logic                s_axilite_awvalid,
  output logic                s_axilite_awready,
  input  logic [31:0]         s_axilite_wdata,
  input  logic [3:0]          s_axilite_wstrb,
  input  logic                s_axilite_wvalid,
  output logic                s_axilite_wready,
  output logic [1:0]          s_axilite_bresp,
  output logic                s_axilite_bvalid,
  input  logic                s_axilite_bready,
  input  logic [ADDR_W-1:0]   s_axilite_araddr,
  input  logic                s_axilite_arvalid,
  output logic                s_axilite_arready,
  output logic [31:0]         s_axilite_rdata,
  output logic [1:0]          s_axilite_rresp,
  output logic                s_axilite_rvalid,
  input  logic                s_axilite_rready,
  input  logic [NUM_CNT-1:0]  cnt_event
);

  localparam int          IDX_W    = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int          SH_W     = CNT_W - 32;
  localparam logic [31:0] CNT_BASE = 32'h100;
  localparam logic [31:0] CNT_END  = 32'h100 + 32'(8 * NUM_CNT);

  typedef enum logic [2:0] {K_BAD, K_CTRL, K_NUM, K_LO, K_HI} kind_e;
  typedef struct packed {
    kind_e            kind;
    logic [IDX_W-1:0] idx;
  } dec_t;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_RESP} r_state_e;

  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    logic [31:0] ax;
    dec_t        d;
    ax     = 32'(a);
    d.kind = K_BAD;
    d.idx  = '0;
    if (ax == 32'h0) begin
      d.kind = K_CTRL;
    end else if (ax == 32'h4) begin
      d.kind = K_NUM;
    end else if (ax >= CNT_BASE && ax < CNT_END && ax[1:0] == 2'b00) begin
      // CNT_BASE is 8-byte aligned, so bit 2 alone selects the high word.
      d.kind = ax[2] ? K_HI : K_LO;
      d.idx  = IDX_W'((ax - CNT_BASE) >> 3);
    end
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] merge_write(input logic [CNT_W-1:0] old,
                                                   input logic hi,
                                                   input logic [31:0] data,
                                                   input logic [3:0] strb);
    logic [63:0] v;
    v = 64'(old);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) v[(hi ? 32 : 0) + 8*b +: 8] = data[8*b +: 8];
    end
    return v[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic             en;
  logic [SH_W-1:0]  shadow;

  // Write channel
  w_state_e          w_state, w_next;
  logic              aw_held, w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;
  logic [1:0]        bresp_q;
  logic              aw_fire, w_fire;
  dec_t              wr_dec;
  logic              wr_exec, ctrl_wr, clr_all, cnt_wr;

  assign aw_fire = s_axilite_awvalid && s_axilite_awready;
  assign w_fire  = s_axilite_wvalid && s_axilite_wready;
  assign wr_dec  = decode(aw_addr_q);
  assign wr_exec = (w_state == W_EXEC);
  assign ctrl_wr = wr_exec && wr_dec.kind == K_CTRL && w_strb_q[0];
  assign clr_all = ctrl_wr && w_data_q[1];
  assign cnt_wr  = wr_exec && (wr_dec.kind == K_LO || wr_dec.kind == K_HI);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_next            = w_state;
    s_axilite_awready = 1'b0;
    s_axilite_wready  = 1'b0;
    s_axilite_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axilite_awready = !aw_held;
        s_axilite_wready  = !w_held;
        if ((aw_held || s_axilite_awvalid) && (w_held || s_axilite_wvalid)) w_next = W_EXEC;
      end
      W_EXEC: w_next = W_RESP;
      W_RESP: begin
        s_axilite_bvalid = 1'b1;
        if (s_axilite_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= 2'b00;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axilite_awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= s_axilite_wdata;
        w_strb_q <= s_axilite_wstrb;
      end
      if (wr_exec) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= (wr_dec.kind == K_BAD) ? 2'b10 : 2'b00;
      end
    end
  end

  assign s_axilite_bresp = bresp_q;

  always_ff @(posedge clk) begin
    if (rst)          en <= 1'b1;
    else if (ctrl_wr) en <= w_data_q[0];
  end

  // Clear beats a register write, which beats the event; a losing event is dropped.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is architecturally visible state, so it is reset like any register.
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clr_all)
          cnt[i] <= '0;
        else if (cnt_wr && wr_dec.idx == IDX_W'(i))
          cnt[i] <= merge_write(cnt[i], wr_dec.kind == K_HI, w_data_q, w_strb_q);
        else if (en && cnt_event[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Read channel
  r_state_e          r_state, r_next;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [31:0]       rdata_q, rd_val;
  logic [1:0]        rresp_q, rd_resp;
  dec_t              rd_dec;

  assign rd_dec = decode(ar_addr_q);

  always_comb begin
    r_next            = r_state;
    s_axilite_arready = 1'b0;
    s_axilite_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axilite_arready = 1'b1;
        if (s_axilite_arvalid) r_next = R_READ;
      end
      R_READ: r_next = R_RESP;
      R_RESP: begin
        s_axilite_rvalid = 1'b1;
        if (s_axilite_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = 2'b00;
    case (rd_dec.kind)
      K_CTRL:  rd_val = {31'b0, en};
      K_NUM:   rd_val = 32'(NUM_CNT);
      K_LO:    rd_val = cnt[rd_dec.idx][31:0];
      K_HI:    rd_val = 32'(shadow);
      default: rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= R_IDLE;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      shadow    <= '0;
    end else begin
      r_state <= r_next;
      if (s_axilite_arvalid && s_axilite_arready) ar_addr_q <= s_axilite_araddr;
      if (r_state == R_READ) begin
        rdata_q <= rd_val;
        rresp_q <= rd_resp;
        if (rd_dec.kind == K_LO) shadow <= cnt[rd_dec.idx][CNT_W-1:32];
      end
    end
  end

  assign s_axilite_rdata = rdata_q;
  assign s_axilite_rresp = rresp_q;

endmodule

// File: tb/tb_perfcnt_bank.sv
// Randomised self-checking bench for perfcnt_bank against a cycle-level
// arithmetic model of the counter bank, CTRL and the shared shadow word.
module tb_perfcnt_bank;

  localparam int NC = 16;

  logic        clk, rst;
  logic [15:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [NC-1:0] cnt_event, dir_ev, rnd_ev;
  logic        rnd_on;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [63:0] m_cnt [NC];
  logic        m_en;
  logic [31:0] m_shadow;
  logic        wr_exec_now;
  logic [15:0] wx_addr;
  logic [31:0] wx_data;
  logic [3:0]  wx_strb;

  perfcnt_bank #(.NUM_CNT(NC), .CNT_W(64), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
    .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid),
    .s_axilite_wready(wready), .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid),
    .s_axilite_bready(bready), .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid),
    .s_axilite_arready(arready), .s_axilite_rdata(rdata), .s_axilite_rresp(rresp),
    .s_axilite_rvalid(rvalid), .s_axilite_rready(rready), .cnt_event(cnt_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cnt_event = dir_ev | rnd_ev;

  always @(negedge clk) rnd_ev <= rnd_on ? NC'($urandom) : '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_cnt_addr(input logic [15:0] a);
    return a >= 16'h0100 && a < 16'(16'h0100 + 8*NC) && a[1:0] == 2'b00;
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    return a == 16'h0000 || a == 16'h0004 || is_cnt_addr(a);
  endfunction

  function automatic logic [63:0] apply_bytes(input logic [63:0] old, input bit hi,
                                              input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    if (hi) return (old & ~{m, 32'h0}) | {d & m, 32'h0};
    return (old & ~{32'h0, m}) | {32'h0, d & m};
  endfunction

  // Model: clear, then targeted write, then event; writes land the cycle after both handshakes.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) m_cnt[i] <= 64'h0;
      m_en <= 1'b1;
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (wr_exec_now && wx_addr == 16'h0 && wx_strb[0] && wx_data[1])
          m_cnt[i] <= 64'h0;
        else if (wr_exec_now && wx_addr == 16'(16'h100 + 8*i))
          m_cnt[i] <= apply_bytes(m_cnt[i], 1'b0, wx_data, wx_strb);
        else if (wr_exec_now && wx_addr == 16'(16'h104 + 8*i))
          m_cnt[i] <= apply_bytes(m_cnt[i], 1'b1, wx_data, wx_strb);
        else if (m_en && cnt_event[i])
          m_cnt[i] <= m_cnt[i] + 64'd1;
      end
      if (wr_exec_now && wx_addr == 16'h0 && wx_strb[0]) m_en <= wx_data[0];
    end
  end

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_stall);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_f, w_f;
    int t = 0;
    logic [1:0] exp_b;
    while (!(aw_done && w_done) && t < 64) begin
      if (!aw_done && t >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
      if (!w_done && t >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
      aw_f = awvalid && awready;
      w_f  = wvalid && wready;
      @(posedge clk); @(negedge clk);
      if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
      if (w_f)  begin wvalid  = 1'b0; w_done  = 1; end
      if (w_done && !aw_done) check("wready_drop", 64'(wready), 64'(1'b0));
      if (aw_done && !w_done) check("awready_drop", 64'(awready), 64'(1'b0));
      t++;
    end
    if (!(aw_done && w_done)) begin
      check("wr_handshake_timeout", 64'(0), 64'(1));
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    wx_addr = addr; wx_data = data; wx_strb = strb; wr_exec_now = 1'b1;
    exp_b = is_mapped(addr) ? 2'b00 : 2'b10;
    check("bvalid_early", 64'(bvalid), 64'(1'b0));
    @(negedge clk);
    wr_exec_now = 1'b0;
    check("bvalid_lat", 64'(bvalid), 64'(1'b1));
    repeat (b_stall) begin
      check("bvalid_hold", 64'(bvalid), 64'(1'b1));
      @(negedge clk);
    end
    bready = 1'b1;
    check($sformatf("bresp %h", addr), 64'(bresp), 64'(exp_b));
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("bvalid_clr", 64'(bvalid), 64'(1'b0));
  endtask

  task automatic axi_read(input logic [15:0] addr, input int ar_dly, input int r_stall,
                          output logic [31:0] data);
    bit done = 0;
    bit f;
    int t = 0;
    int i;
    logic [31:0] exp_d, held;
    logic [1:0]  exp_r;
    data = '0;
    while (!done && t < 64) begin
      if (t >= ar_dly) begin arvalid = 1'b1; araddr = addr; end
      f = arvalid && arready;
      @(posedge clk); @(negedge clk);
      if (f) begin arvalid = 1'b0; done = 1; end
      t++;
    end
    if (!done) begin
      check("ar_timeout", 64'(0), 64'(1));
      arvalid = 1'b0;
      return;
    end
    // Value is the model state entering the sampling cycle.
    exp_r = 2'b00;
    if (addr == 16'h0) exp_d = {31'b0, m_en};
    else if (addr == 16'h4) exp_d = NC;
    else if (is_cnt_addr(addr)) begin
      i = int'(addr - 16'h100) / 8;
      if (addr[2]) exp_d = m_shadow;
      else begin
        exp_d    = m_cnt[i][31:0];
        m_shadow = m_cnt[i][63:32];
      end
    end else begin
      exp_d = 32'h0;
      exp_r = 2'b10;
    end
    check("rvalid_early", 64'(rvalid), 64'(1'b0));
    @(negedge clk);
    check("rvalid_lat", 64'(rvalid), 64'(1'b1));
    held = rdata;
    repeat (r_stall) begin
      @(negedge clk);
      check("rvalid_hold", 64'(rvalid), 64'(1'b1));
      check("rdata_hold", 64'(rdata), 64'(held));
    end
    rready = 1'b1;
    check($sformatf("rdata %h", addr), 64'(rdata), 64'(exp_d));
    check($sformatf("rresp %h", addr), 64'(rresp), 64'(exp_r));
    data = rdata;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    check("rvalid_clr", 64'(rvalid), 64'(1'b0));
  endtask

  task automatic pulse(input int idx, input int n);
    repeat (n) begin
      dir_ev[idx] = 1'b1;
      @(negedge clk);
    end
    dir_ev[idx] = 1'b0;
  endtask

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'h0004;
    if (r == 2) return 16'h0200;
    if (r == 3) return 16'h0102;
    return 16'(16'h100 + 8*$urandom_range(0, NC-1) + ($urandom_range(0, 1) ? 4 : 0));
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [15:0] wa;
    logic [31:0] wd;
    rst = 1'b1; rnd_on = 1'b0; dir_ev = '0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    wr_exec_now = 0; wx_addr = '0; wx_data = '0; wx_strb = '0; m_shadow = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_awready", 64'(awready), 64'(1'b1));
    check("rst_wready",  64'(wready),  64'(1'b1));
    check("rst_arready", 64'(arready), 64'(1'b1));
    check("rst_bvalid",  64'(bvalid),  64'(1'b0));
    check("rst_rvalid",  64'(rvalid),  64'(1'b0));
    check("rst_rdata",   64'(rdata),   64'(0));

    axi_read(16'h0004, 0, 0, d);  check("num", 64'(d), 64'(NC));
    axi_read(16'h0000, 0, 0, d);  check("ctrl_rst", 64'(d), 64'(1));

    pulse(3, 5);
    axi_read(16'h0118, 0, 0, d);  check("cnt3", 64'(d), 64'(5));
    axi_write(16'h0000, 32'h0, 4'hF, 0, 0, 0);
    pulse(3, 4);
    axi_read(16'h0118, 0, 0, d);  check("cnt3_frozen", 64'(d), 64'(5));
    axi_write(16'h0000, 32'h1, 4'hF, 0, 0, 0);

    axi_write(16'h0114, 32'h0000_0001, 4'hF, 0, 0, 0);
    axi_write(16'h0110, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    pulse(2, 1);
    axi_read(16'h0110, 0, 0, d);  check("wrap_lo", 64'(d), 64'(0));
    pulse(2, 1);
    axi_read(16'h0114, 0, 0, d);  check("shadow_hi", 64'(d), 64'(2));

    dir_ev[0] = 1'b1;
    axi_write(16'h0000, 32'h3, 4'hF, 0, 0, 0);
    dir_ev[0] = 1'b0;
    axi_read(16'h0118, 0, 0, d);  check("clr_cnt3", 64'(d), 64'(0));
    axi_read(16'h0110, 0, 0, d);  check("clr_cnt2", 64'(d), 64'(0));
    axi_read(16'h0100, 0, 0, d);
    axi_read(16'h0000, 0, 0, d);  check("ctrl_after_clr", 64'(d), 64'(1));
    dir_ev[0] = 1'b1;
    axi_write(16'h0100, 32'h0000_1234, 4'hF, 0, 0, 0);
    dir_ev[0] = 1'b0;
    axi_read(16'h0100, 0, 0, d);

    axi_write(16'h0000, 32'h0, 4'b1110, 0, 0, 0);
    axi_read(16'h0000, 0, 0, d);  check("ctrl_nostrb", 64'(d), 64'(1));

    axi_write(16'h0120, 32'hCAFE_0001, 4'hF, 2, 0, 3);
    axi_write(16'h0124, 32'hAABB_CCDD, 4'b0101, 0, 1, 0);
    axi_read(16'h0120, 0, 2, d);
    axi_read(16'h0124, 1, 0, d);
    axi_write(16'h0200, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
    axi_read(16'h0200, 0, 0, d);
    axi_read(16'h0120, 0, 0, d);

    rnd_on = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wa = rand_addr();
      wd = $urandom;
      if (wa == 16'h0) wd = {30'b0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0)};
      fork
        axi_write(wa, wd, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        axi_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), d);
      join
    end
    rnd_on = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      axi_read(16'(16'h100 + 8*i), 0, 0, d);
      axi_read(16'(16'h104 + 8*i), 0, 0, d);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
